fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the MIPS pipeline. It owns the program counter and drives the byte address into the combinational instruction memory. It captures the returned word into the IF/ID pipeline register, and applies stall, branch/jump redirect and squash. Out-of-range fetches park the stage in a halted state instead of reading undefined memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
IMEM_WORDS, 27, number of valid instruction words; legal fetch addresses are 0 .. 4*IMEM_WORDS-4
NOP_WORD, 32'h0000_0000, word injected into IF/ID on squash, reset or halt
COUNT_W, 16, width of the fetched-instruction counter

Ports:
Clk  input  1  system clock; all state updates on rising edge
Rst  input  1  synchronous reset, active-high
Stall  input  1  hazard unit: hold PC and IF/ID this cycle
Branch  input  1  ID stage: taken branch, redirect to BranchTarget
BranchTarget  input  32  branch target byte address from ID
Jump  input  1  ID stage: j instruction, redirect to jump target
JumpIndex  input  26  instr[25:0] of the jump in ID
Instruction  input  32  word returned by instruction memory for Address (same cycle, combinational)
Address  output  32  current PC, byte address to instruction memory
IFID_Instruction  output  32  registered instruction for decode
IFID_PCPlus4  output  32  registered PC+4 of that instruction
IFID_Valid  output  1  1 = IFID_Instruction is a real fetched instruction
FetchFault  output  1  1 while in HALT state
FetchCount  output  COUNT_W  number of valid instructions loaded into IF/ID, saturating

Behaviour:
- Reset (Rst=1 at edge, overrides everything):
  - PC=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0.
  - FetchCount=0, state=RUN, FetchFault=0.
- Address = PC, combinational. Instruction is sampled in the same cycle: fetch-to-IF/ID latency is 1 clock.
- Jump target = {IFID_PCPlus4[31:28], JumpIndex, 2'b00}. BranchTarget[1:0] is forced to 00 before use.
- Priority each edge, after Rst: redirect (Jump over Branch if both asserted) > HALT > Stall > normal advance.
- Redirect: the wrong-path instruction is squashed.
  - PC=target.
  - IFID_Instruction=NOP_WORD, IFID_Valid=0, IFID_PCPlus4 unchanged.
  - state=RUN.
  - Redirect overrides Stall and clears HALT.
- State RUN, in range (PC[31:2] < IMEM_WORDS), Stall=0:
  - PC=PC+4 (32-bit wrap, no carry out).
  - IFID_Instruction=Instruction, IFID_PCPlus4=PC+4, IFID_Valid=1.
  - FetchCount+1, saturating at 2^COUNT_W-1.
- State RUN, Stall=1, no redirect: PC, IF/ID, FetchCount and state all hold.
- State RUN, PC out of range, no redirect:
  - Go to HALT, regardless of Stall.
  - PC holds, IFID_Instruction=NOP_WORD, IFID_Valid=0, FetchCount holds.
- State HALT:
  - FetchFault=1, PC holds, IF/ID holds NOP/invalid; Stall is ignored.
  - Only a redirect (or Rst) leaves HALT.
  - If the redirect target is itself out of range, the stage returns to HALT on the next edge.
- FetchFault is a registered decode of state: asserted the cycle after the out-of-range PC is detected.
- Reset mid-stall, mid-redirect or in HALT: all values return to reset values; no residual squash.

Decomposition:
- Shared package (mips_pkg):
  - NOP_WORD
  - opcode/field position constants (JumpIndex slice 25:0, PC upper nibble 31:28)
  - fetch state enum {RUN, HALT}
- Natural sub-module: ifid_register, which holds Instruction, PCPlus4 and Valid, with load/hold/squash controls and synchronous reset.
- PC, next-PC mux and the HALT state machine stay in fetch_stage.

Test Plan:
- Reset then 3 free-running cycles, IMEM = addi/addi/addi -> Address 0,4,8,12.
  - IFID_PCPlus4 4,8,12; IFID_Valid 0 then 1,1,1; FetchCount=3.
- Stall=1 for 2 cycles at PC=0x10 -> Address stays 0x10; IF/ID and FetchCount unchanged.
  - After release, the next edge loads the word at 0x10 with PCPlus4=0x14.
- Jump with JumpIndex=7 while IFID_PCPlus4=0x68, Stall=1 same cycle -> next Address=0x1C, IFID_Valid=0, IFID_Instruction=0.
  - The following edge fetches 0x1C.
- Branch=1, BranchTarget=0x17 together with Jump=1, JumpIndex=2 -> Jump wins, Address=0x08.
  - Separate test, Branch alone with BranchTarget=0x17 -> Address=0x14.
- Sequential run to PC=0x6C (IMEM_WORDS=27) -> HALT: FetchFault=1 next cycle, Address held at 0x6C, IFID_Valid=0, FetchCount=27.
  - Branch to 0x00 -> FetchFault=0, Address=0.
- Rst asserted while in HALT with FetchCount=27 -> next edge Address=RESET_PC, FetchCount=0, FetchFault=0, IFID_Valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants, fetch FSM state encoding and the jump-target helper.
// Pure declarations: no latency, no backpressure.
package mips_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Bit positions of the j-format index field and the PC region nibble.
    localparam int JIDX_MSB  = 25;
    localparam int JIDX_LSB  = 0;
    localparam int PC_HI_MSB = 31;
    localparam int PC_HI_LSB = 28;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] jump_target(input logic [31:0]             pcplus4,
                                                input logic [JIDX_MSB:JIDX_LSB] idx);
        return {pcplus4[PC_HI_MSB:PC_HI_LSB], idx, 2'b00};
    endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: load captures a fetched word, squash injects a bubble, neither holds.
// Latency 1 clock; hold is the only backpressure (driven by the fetch stage's stall).
module ifid_register
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_VAL = NOP_WORD
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        load,
    input  logic        squash,
    input  logic [31:0] instr_in,
    input  logic [31:0] pcplus4_in,
    output logic [31:0] instr_out,
    output logic [31:0] pcplus4_out,
    output logic        valid_out
);

    logic [31:0] instr_q,   instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q,   valid_d;

    // Squash wins over load; PC+4 survives a squash so a later jump can still use its region bits.
    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (squash) begin
            instr_d = NOP_VAL;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d   = instr_in;
            pcplus4_d = pcplus4_in;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            instr_q   <= NOP_VAL;
            pcplus4_q <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_out   = instr_q;
    assign pcplus4_out = pcplus4_q;
    assign valid_out   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives combinational IMEM, fills IF/ID; out-of-range PC parks in HALT.
// Fetch-to-IF/ID latency 1 clock; Stall holds PC and IF/ID, redirects override Stall and HALT.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 27,
    parameter logic [31:0] NOP_WORD   = mips_pkg::NOP_WORD,
    parameter int          COUNT_W    = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Stall,
    input  logic                     Branch,
    input  logic [31:0]              BranchTarget,
    input  logic                     Jump,
    input  logic [JIDX_MSB:JIDX_LSB] JumpIndex,
    input  logic [31:0]              Instruction,
    output logic [31:0]              Address,
    output logic [31:0]              IFID_Instruction,
    output logic [31:0]              IFID_PCPlus4,
    output logic                     IFID_Valid,
    output logic                     FetchFault,
    output logic [COUNT_W-1:0]       FetchCount
);

    localparam logic [31:0]        IMEM_LIMIT = 32'(IMEM_WORDS);
    localparam logic [COUNT_W-1:0] COUNT_MAX  = {COUNT_W{1'b1}};

    logic [31:0]        pc_q,    pc_d;
    fetch_state_e       state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic        redirect;
    logic        in_range;
    logic [31:0] branch_tgt;
    logic [31:0] redirect_tgt;
    logic [31:0] pc_plus4;
    logic        ifid_load;
    logic        ifid_squash;

    assign redirect     = Jump | Branch;
    assign branch_tgt   = BranchTarget & ~32'h3;
    assign redirect_tgt = Jump ? jump_target(IFID_PCPlus4, JumpIndex) : branch_tgt;
    assign in_range     = {2'b00, pc_q[31:2]} < IMEM_LIMIT;
    assign pc_plus4     = pc_q + 32'd4;

    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        count_d     = count_q;
        ifid_load   = 1'b0;
        ifid_squash = 1'b0;
        if (redirect) begin
            pc_d        = redirect_tgt;
            state_d     = RUN;
            ifid_squash = 1'b1;
        end else if (state_q == HALT) begin
            // Parked: only a redirect or reset moves us.
        end else if (!in_range) begin
            state_d     = HALT;
            ifid_squash = 1'b1;
        end else if (!Stall) begin
            pc_d      = pc_plus4;
            ifid_load = 1'b1;
            if (count_q != COUNT_MAX) begin
                count_d = count_q + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    ifid_register #(
        .NOP_VAL (NOP_WORD)
    ) u_ifid (
        .Clk         (Clk),
        .Rst         (Rst),
        .load        (ifid_load),
        .squash      (ifid_squash),
        .instr_in    (Instruction),
        .pcplus4_in  (pc_plus4),
        .instr_out   (IFID_Instruction),
        .pcplus4_out (IFID_PCPlus4),
        .valid_out   (IFID_Valid)
    );

    assign Address    = pc_q;
    assign FetchFault = (state_q == HALT);
    assign FetchCount = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural reference and an expected-output queue.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst, Stall, Branch, Jump;
    logic [31:0] BranchTarget;
    logic [25:0] JumpIndex;
    logic [31:0] Instruction;
    logic [31:0] Address, IFID_Instruction, IFID_PCPlus4;
    logic        IFID_Valid, FetchFault;
    logic [15:0] FetchCount;

    always #5 Clk = ~Clk;

    fetch_stage dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .Stall            (Stall),
        .Branch           (Branch),
        .BranchTarget     (BranchTarget),
        .Jump             (Jump),
        .JumpIndex        (JumpIndex),
        .Instruction      (Instruction),
        .Address          (Address),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .FetchFault       (FetchFault),
        .FetchCount       (FetchCount)
    );

    logic [31:0] imem [27];
    initial for (int i = 0; i < 27; i++) imem[i] = 32'h2008_0000 + i;

    always_comb begin
        if (Address < 32'd108) Instruction = imem[Address[6:2]];
        else                   Instruction = 32'hDEAD_BEEF;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] cnt;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halt;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic stall, input logic br,
                       input logic [31:0] bt, input logic jmp, input logic [25:0] ji);
        exp_t e;
        logic [31:0] tgt;
        Rst = rst; Stall = stall; Branch = br; BranchTarget = bt; Jump = jmp; JumpIndex = ji;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 16'h0; m_halt = 1'b0;
        end else if (jmp || br) begin
            tgt     = jmp ? {m_pc4[31:28], ji, 2'b00} : {bt[31:2], 2'b00};
            m_pc    = tgt;
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_halt  = 1'b0;
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (m_pc >= 32'd108) begin
            m_halt  = 1'b1;
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (!stall) begin
            m_instr = imem[m_pc[6:2]];
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, cnt: m_cnt, fault: m_halt};
        sb.push_back(e);
        @(posedge Clk);
        #1;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_bad++;
            $error("FAIL sb_empty: observed %0d entries expected at least 1", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("Address",          Address,               e.pc);
            check("IFID_Instruction", IFID_Instruction,      e.instr);
            check("IFID_PCPlus4",     IFID_PCPlus4,          e.pc4);
            check("IFID_Valid",       {31'h0, IFID_Valid},   {31'h0, e.valid});
            check("FetchCount",       {16'h0, FetchCount},   {16'h0, e.cnt});
            check("FetchFault",       {31'h0, FetchFault},   {31'h0, e.fault});
        end
        @(negedge Clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    endtask

    initial begin
        Rst = 1'b0; Stall = 1'b0; Branch = 1'b0; Jump = 1'b0; BranchTarget = 32'h0; JumpIndex = 26'h0;
        @(negedge Clk);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        cyc(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 26'h0);
        check("rst_addr",  Address, 32'h0);
        check("rst_valid", {31'h0, IFID_Valid}, 32'h0);
        check("rst_count", {16'h0, FetchCount}, 32'h0);

        run(3);
        check("run3_addr",  Address, 32'd12);
        check("run3_pc4",   IFID_PCPlus4, 32'd12);
        check("run3_count", {16'h0, FetchCount}, 32'd3);

        run(1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        check("stall_addr",  Address, 32'h10);
        check("stall_count", {16'h0, FetchCount}, 32'd4);
        run(1);
        check("release_pc4",   IFID_PCPlus4, 32'h14);
        check("release_instr", IFID_Instruction, 32'h2008_0004);

        run(21);
        check("prejump_pc4", IFID_PCPlus4, 32'h68);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 26'd7);
        check("jump_addr",  Address, 32'h1C);
        check("jump_valid", {31'h0, IFID_Valid}, 32'h0);
        check("jump_instr", IFID_Instruction, 32'h0);
        run(1);
        check("postjump_pc4", IFID_PCPlus4, 32'h20);

        cyc(1'b0, 1'b0, 1'b1, 32'h17, 1'b1, 26'd2);
        check("jump_over_branch", Address, 32'h08);
        cyc(1'b0, 1'b0, 1'b1, 32'h17, 1'b0, 26'd0);
        check("branch_align", Address, 32'h14);

        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        run(27);
        check("prehalt_addr",  Address, 32'h6C);
        check("prehalt_fault", {31'h0, FetchFault}, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        check("halt_fault", {31'h0, FetchFault}, 32'h1);
        check("halt_addr",  Address, 32'h6C);
        check("halt_count", {16'h0, FetchCount}, 32'd27);
        run(2);
        check("halt_hold", Address, 32'h6C);
        cyc(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 26'h0);
        check("unhalt_fault", {31'h0, FetchFault}, 32'h0);
        check("unhalt_addr",  Address, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 26'h0);
        run(1);
        check("rehalt_fault", {31'h0, FetchFault}, 32'h1);
        check("rehalt_count", {16'h0, FetchCount}, 32'd27);

        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        check("haltrst_addr",  Address, 32'h0);
        check("haltrst_count", {16'h0, FetchCount}, 32'd0);
        check("haltrst_fault", {31'h0, FetchFault}, 32'h0);
        run(1);
        check("postrst_valid", {31'h0, IFID_Valid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
